// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with round-robin on contention,
// one-cycle registered write port, in-flight hazard flag and a saturating conflict counter.
module rf_wb_arbiter #(
  parameter int N  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          v0,
  input  logic [4:0]    a0,
  input  logic [N-1:0]  d0,
  output logic          r0,
  input  logic          v1,
  input  logic [4:0]    a1,
  input  logic [N-1:0]  d1,
  output logic          r1,
  output logic          we3,
  output logic [4:0]    wa3,
  output logic [N-1:0]  wd3,
  input  logic [4:0]    chka,
  output logic          pend,
  output logic [CW-1:0] conflicts
);

  logic         lp_r;
  logic         contested_s;
  logic         xfer_s;
  logic [4:0]   xa_s;
  logic [N-1:0] xd_s;

  // Grant selection: lp_r holds the winner of the last contested cycle, so the other side wins next.
  always_comb begin
    r0          = 1'b0;
    r1          = 1'b0;
    contested_s = 1'b0;
    if (reset) begin
      r0          = 1'b0;
      r1          = 1'b0;
      contested_s = 1'b0;
    end else if (v0 && v1) begin
      contested_s = 1'b1;
      r0          = lp_r;
      r1          = ~lp_r;
    end else begin
      r0 = v0;
      r1 = v1;
    end
  end

  // Mux the accepted request onto the internal transfer bus.
  always_comb begin
    xfer_s = r0 | r1;
    xa_s   = 5'd0;
    xd_s   = {N{1'b0}};
    if (r1) begin
      xa_s = a1;
      xd_s = d1;
    end else if (r0) begin
      xa_s = a0;
      xd_s = d0;
    end else begin
      xa_s = 5'd0;
      xd_s = {N{1'b0}};
    end
  end

  // Hazard flag: write already on the port or being accepted right now; x0 never counts.
  always_comb begin
    pend = 1'b0;
    if (chka != 5'd0) begin
      pend = (we3 && (wa3 == chka)) || (xfer_s && (xa_s == chka));
    end else begin
      pend = 1'b0;
    end
  end

  // Registered write port, round-robin pointer and saturating conflict counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3       <= 1'b0;
      wa3       <= 5'd0;
      wd3       <= {N{1'b0}};
      lp_r      <= 1'b0;
      conflicts <= {CW{1'b0}};
    end else begin
      we3 <= xfer_s && (xa_s != 5'd0);
      if (xfer_s) begin
        wa3 <= xa_s;
        wd3 <= xd_s;
      end
      if (contested_s) begin
        lp_r <= r1;
        if (conflicts != {CW{1'b1}}) begin
          conflicts <= conflicts + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized self-checking bench for rf_wb_arbiter: a behavioural model is compared
// every cycle, plus directed sequences with hand-computed expectations.
module tb_rf_wb_arbiter;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          v0, v1;
  logic [4:0]    a0, a1, chka;
  logic [N-1:0]  d0, d1;
  logic          r0, r1, we3, pend;
  logic [4:0]    wa3;
  logic [N-1:0]  wd3;
  logic [3:0]    conflicts;
  logic          s_r0, s_r1, s_we3, s_pend;
  logic [4:0]    s_wa3;
  logic [N-1:0]  s_wd3;
  logic [1:0]    s_conflicts;

  int n_pass  = 0;
  int n_total = 0;

  // behavioural model state
  int           m_last;  // winner of most recent contested cycle
  int           m_cnt;   // contested cycles since reset (unsaturated)
  logic         m_we;
  logic [4:0]   m_wa;
  logic [N-1:0] m_wd;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.N(N), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .we3(we3), .wa3(wa3), .wd3(wd3),
    .chka(chka), .pend(pend), .conflicts(conflicts)
  );

  rf_wb_arbiter #(.N(N), .CW(2)) dut_small (
    .clk(clk), .reset(reset),
    .v0(v0), .a0(a0), .d0(d0), .r0(s_r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(s_r1),
    .we3(s_we3), .wa3(s_wa3), .wd3(s_wd3),
    .chka(chka), .pend(s_pend), .conflicts(s_conflicts)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // who wins this cycle by the spec rules: -1 none, 0 or 1
  function automatic int winner(input logic rst, input logic q0, input logic q1, input int last);
    if (rst) return -1;
    if (q0 && q1) return 1 - last;
    if (q0) return 0;
    if (q1) return 1;
    return -1;
  endfunction

  function automatic int sat(input int cnt, input int maxv);
    return (cnt > maxv) ? maxv : cnt;
  endfunction

  // model update on the clock edge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last <= 0;
      m_cnt  <= 0;
      m_we   <= 1'b0;
      m_wa   <= 5'd0;
      m_wd   <= '0;
    end else begin
      int w;
      w = winner(1'b0, v0, v1, m_last);
      m_we <= 1'b0;
      if (w >= 0) begin
        m_we <= ((w == 1) ? a1 : a0) != 5'd0;
        m_wa <= (w == 1) ? a1 : a0;
        m_wd <= (w == 1) ? d1 : d0;
      end
      if (v0 && v1) begin
        m_cnt  <= m_cnt + 1;
        m_last <= w;
      end
    end
  end

  // compare process: every falling edge, both instances against the model
  always @(negedge clk) begin
    int w;
    logic [4:0] xa;
    logic ep;
    w  = winner(reset, v0, v1, m_last);
    xa = (w == 1) ? a1 : a0;
    ep = (chka != 5'd0) && ((m_we && m_wa == chka) || (w >= 0 && xa != 5'd0 && xa == chka));
    chk("r0", r0, w == 0);
    chk("r1", r1, w == 1);
    chk("we3", we3, m_we);
    chk("wa3", wa3, m_wa);
    chk("wd3", wd3, m_wd);
    chk("pend", pend, ep);
    chk("conflicts", conflicts, sat(m_cnt, 15));
    chk("small_grant", {s_r0, s_r1}, {w == 0, w == 1});
    chk("small_port", {s_we3, s_wa3, s_wd3}, {m_we, m_wa, m_wd});
    chk("small_pend", s_pend, ep);
    chk("small_conflicts", s_conflicts, sat(m_cnt, 3));
  end

  task automatic drive(input logic q0, input logic [4:0] x0, input logic [N-1:0] e0,
                       input logic q1, input logic [4:0] x1, input logic [N-1:0] e1,
                       input logic [4:0] ck);
    v0 = q0; a0 = x0; d0 = e0; v1 = q1; a1 = x1; d1 = e1; chka = ck;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    repeat (3) next();
    reset = 1'b0;

    // single ALU write
    drive(1'b1, 5'd5, 32'h11, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("d_r0", r0, 1'b1);
    next(); drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("d_wr", {we3, wa3, wd3}, {1'b1, 5'd5, 32'h11});
    next();
    @(negedge clk); chk("d_we_off", we3, 1'b0);

    // four contested cycles
    next(); drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 5'd0);
    @(negedge clk); chk("rr0", {r0, r1}, 2'b01);
    next(); @(negedge clk); chk("rr1", {r0, r1, wa3}, {2'b10, 5'd2});
    next(); @(negedge clk); chk("rr2", {r0, r1, wa3}, {2'b01, 5'd1});
    next(); @(negedge clk); chk("rr3", {r0, r1, wa3}, {2'b10, 5'd2});
    next(); drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("rr_tail", {we3, wa3, wd3, conflicts}, {1'b1, 5'd1, 32'hA, 4'd4});

    // write to x0
    next(); drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'hFF, 5'd0);
    @(negedge clk); chk("z_r1", r1, 1'b1);
    next(); drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("z_port", {we3, wa3, wd3}, {1'b0, 5'd0, 32'hFF});

    // hazard flag
    next(); drive(1'b1, 5'd7, 32'h3, 1'b0, 5'd0, '0, 5'd7);
    @(negedge clk); chk("p_t", pend, 1'b1);
    next(); drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd7);
    @(negedge clk); chk("p_t1", pend, 1'b1);
    next(); @(negedge clk); chk("p_t2", pend, 1'b0);
    next(); drive(1'b1, 5'd0, 32'h4, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("p_zero", pend, 1'b0);

    // saturation
    next(); drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2, 5'd0);
    repeat (20) next();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("sat", {conflicts, s_conflicts}, {4'd15, 2'd3});

    // reset right after a transfer
    next(); drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, '0, 5'd0);
    next(); drive(1'b1, 5'd3, 32'h66, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("x_we", we3, 1'b1);
    #1 reset = 1'b1;
    #1 chk("x_clear", {we3, wa3, wd3, conflicts}, {1'b0, 5'd0, 32'h0, 4'd0});
    next(); @(negedge clk); chk("x_nogrant", r0, 1'b0);
    next(); reset = 1'b0; drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0, 5'd0);
    @(negedge clk); chk("x_post0", we3, 1'b0);
    next(); @(negedge clk); chk("x_post1", we3, 1'b0);

    // first contested grant after reset
    next(); drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 5'd0);
    @(negedge clk); chk("x_first_rr", {r0, r1}, 2'b01);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      next();
      reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)));
    end
    next(); reset = 1'b0;
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter N, default 32, data width of register write data.
REQ-002 Parameter CW, default 16, width of the conflict counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 v0  input  1  requester 0 (ALU writeback) write request valid.
REQ-006 a0  input  5  requester 0 destination register address.
REQ-007 d0  input  N  requester 0 write data.
REQ-008 r0  output  1  requester 0 accepted this cycle (combinational grant).
REQ-009 v1  input  1  requester 1 (memory/load writeback) write request valid.
REQ-010 a1  input  5  requester 1 destination register address.
REQ-011 d1  input  N  requester 1 write data.
REQ-012 r1  output  1  requester 1 accepted this cycle (combinational grant).
REQ-013 we3  output  1  registered write enable to the register file.
REQ-014 wa3  output  5  registered write address to the register file.
REQ-015 wd3  output  N  registered write data to the register file.
REQ-016 chka  input  5  hazard-check address.
REQ-017 pend  output  1  chka matches an in-flight write (combinational).
REQ-018 conflicts  output  CW  count of cycles with v0 and v1 both high.

Function
REQ-019 A transfer on requester k occurs in a cycle where vk=1 and rk=1; at most one of r0/r1 is high per cycle.
REQ-020 Only v0 high: r0=1; only v1 high: r1=1; neither: r0=r1=0.
REQ-021 Both high: grant goes to the requester not granted in the most recent contested cycle (round-robin pointer lp, 1 bit).
REQ-022 lp updates only in contested cycles, to the granted index; uncontested grants leave lp unchanged.
REQ-023 Contested cycles with lp=0 grant requester 1; lp=1 grant requester 0.
REQ-024 Latency: a transfer in cycle t drives we3/wa3/wd3 with its address/data in cycle t+1 only.
REQ-025 Transfer with address 0: accepted (rk=1), but we3=0 in cycle t+1; wa3/wd3 still updated.
REQ-026 No transfer in cycle t: we3=0 in cycle t+1; wa3/wd3 hold previous values.
REQ-027 Both requesters with the same nonzero address in one cycle: no merging; loser waits and is written the next granted cycle, so writes reach the register file in grant order.
REQ-028 Requester inputs need not be held stable while waiting; the arbiter samples only in the grant cycle.
REQ-029 pend=1 when chka!=0 and either (a) we3=1 and wa3=chka, or (b) a transfer with nonzero address equal to chka occurs this cycle; else 0.
REQ-030 conflicts increments by 1 each cycle with v0=v1=1; saturates at all-ones, never wraps.

Reset
REQ-031 While reset=1: we3=0, wa3=0, wd3=0, conflicts=0, lp=0, asynchronously.
REQ-032 r0/r1 are forced to 0 while reset=1; requests during reset are not accepted and produce no writes.
REQ-033 A transfer in the cycle reset asserts is discarded; first post-reset contested grant goes to requester 1.

Verification
REQ-034 Reset, then v0=1,a0=5,d0=0x11 for one cycle -> r0=1 that cycle; next cycle we3=1,wa3=5,wd3=0x11; following cycle we3=0.
REQ-035 v0=v1=1 held 4 cycles (a0=1,a1=2) -> grants r1,r0,r1,r0; we3 writes addresses 2,1,2,1 one cycle later; conflicts=4.
REQ-036 v1=1,a1=0,d1=0xFF -> r1=1; next cycle we3=0, wa3=0, wd3=0xFF.
REQ-037 chka=7, transfer a0=7 in cycle t -> pend=1 in t and t+1; pend=0 in t+2 absent new writes; chka=0 -> pend=0 always.
REQ-038 CW=2, both valid 6 cycles -> conflicts reaches 3 and stays 3.
REQ-039 Assert reset in cycle after a transfer -> we3/wa3/wd3 drop to 0 immediately; no write is issued after reset releases.
